seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexes one shared 4-bit-in / 7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a tear-free display register. New values are captured on a load pulse and committed only at a frame boundary.
- Each digit slot is a blanking (anti-ghosting) interval followed by a lit interval.
- Sits between the counter / datapath logic and the segment decoder plus anode drivers on the board.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 18 +
 rtl/seven_seg_scan_timer.sv | 59 +++++
 rtl/seven_seg_scan_ctrl.sv | 76 +++++++
 tb/tb_seven_seg_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 32;

  // Applies board polarity to a one-hot "lit" vector; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_drive(input logic [MAX_DIGITS-1:0] onehot,
                                                        input logic active_low);
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot timer: BLANK then SHOW per digit, advancing the digit index after each SHOW.
module seven_seg_scan_timer
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             show_next,
  output logic [IDX_W-1:0] idx_next,
  output logic             slot_end,
  output logic             wrap
);

  localparam int MAX_LIM = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx;
  logic             blank_end;
  logic             last_idx;

  assign blank_end = (state == BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = (state == SHOW) && (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_idx  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap      = slot_end && last_idx;
  assign show_next = (state_nxt == SHOW);

  always_comb begin
    state_nxt = state;
    idx_next  = idx;
    cnt_nxt   = cnt + CNT_W'(1);
    if (blank_end) begin
      state_nxt = SHOW;
      cnt_nxt   = '0;
    end else if (slot_end) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_next  = last_idx ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_next;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with tear-free, frame-aligned display updates.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  output logic [NIBBLE_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]          anode,
  output logic                           frame_done,
  output logic                           load_ack
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    NUM_DIGITS'(anode_drive('0, ANODE_ACTIVE_LOW != 0));

  logic                           show_next;
  logic [IDX_W-1:0]               idx_next;
  logic                           slot_end;
  logic                           wrap;
  logic [NIBBLE_W*NUM_DIGITS-1:0] disp_reg, disp_next;
  logic [NIBBLE_W*NUM_DIGITS-1:0] pending;
  logic                           pending_valid;
  logic [NUM_DIGITS-1:0]          sel_next;

  seven_seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .show_next(show_next),
    .idx_next (idx_next),
    .slot_end (slot_end),
    .wrap     (wrap)
  );

  // Outputs are driven from next-state values so anode/nibble line up with the timer state.
  assign disp_next = (wrap && pending_valid) ? pending : disp_reg;
  assign sel_next  = show_next ? ((NUM_DIGITS'(1) << idx_next) & digit_en) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg      <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      nibble_out    <= '0;
      anode         <= ANODE_OFF;
      frame_done    <= 1'b0;
      load_ack      <= 1'b0;
    end else begin
      disp_reg <= disp_next;
      if (load) begin
        pending       <= value_in;
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
      if (slot_end) nibble_out <= disp_next[NIBBLE_W*int'(idx_next) +: NIBBLE_W];
      anode      <= NUM_DIGITS'(anode_drive(MAX_DIGITS'(sel_next), ANODE_ACTIVE_LOW != 0));
      frame_done <= wrap;
      load_ack   <= wrap && pending_valid;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, 2 blank and 4 lit cycles per slot.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  nibble_out;
  logic [3:0]  anode;
  logic        frame_done;
  logic        load_ack;

  int errors = 0;
  int checks = 0;
  int k = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS      (4),
    .REFRESH_DIV     (4),
    .BLANK_CYCLES    (2),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value_in  (value_in),
    .digit_en  (digit_en),
    .nibble_out(nibble_out),
    .anode     (anode),
    .frame_done(frame_done),
    .load_ack  (load_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Checks one 24-cycle frame starting at a frame-start sample; optional loads at sample la/lb.
  task automatic check_frame(input logic [15:0] disp, input logic ack, input logic [3:0] mask,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
    logic [3:0] exp_an, exp_nib;
    logic       exp_fd, exp_ack;
    int         s, ph;
    digit_en = mask;
    for (int j = 0; j < 24; j++) begin
      s  = j / 6;
      ph = j % 6;
      exp_an  = (ph < 2 || !mask[s]) ? 4'hF : ~(4'b0001 << s);
      exp_nib = disp[4*s +: 4];
      exp_fd  = (j == 0) && (k != 0);
      exp_ack = (j == 0) && ack;
      checks++;
      if (anode !== exp_an) begin
        errors++;
        $display("FAIL anode k=%0d j=%0d got=%h want=%h", k, j, anode, exp_an);
      end
      checks++;
      if (nibble_out !== exp_nib) begin
        errors++;
        $display("FAIL nibble k=%0d j=%0d got=%h want=%h", k, j, nibble_out, exp_nib);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_done k=%0d j=%0d got=%b want=%b", k, j, frame_done, exp_fd);
      end
      checks++;
      if (load_ack !== exp_ack) begin
        errors++;
        $display("FAIL load_ack k=%0d j=%0d got=%b want=%b", k, j, load_ack, exp_ack);
      end
      if (j == la) begin
        load = 1'b1; value_in = va;
      end else if (j == lb) begin
        load = 1'b1; value_in = vb;
      end
      step();
      load = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (anode !== 4'hF) begin
      errors++; $display("FAIL reset_anode got=%h want=F", anode);
    end
    checks++;
    if (nibble_out !== 4'h0 || frame_done !== 1'b0 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got nib=%h fd=%b ack=%b want 0/0/0", nibble_out, frame_done, load_ack);
    end
    rst_n = 1'b1;
    k = 0;
    check_frame(16'h0000, 1'b0, 4'hF, -1, '0, -1, '0);
    check_frame(16'h0000, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_commit();
    check_frame(16'h0000, 1'b0, 4'hF, 5, 16'h3A7C, -1, '0);
    check_frame(16'h3A7C, 1'b1, 4'hF, -1, '0, -1, '0);
    check_frame(16'h3A7C, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_overwrite();
    check_frame(16'h3A7C, 1'b0, 4'hF, 3, 16'h1111, 6, 16'h2222);
    check_frame(16'h2222, 1'b1, 4'hF, -1, '0, -1, '0);
    check_frame(16'h2222, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_wrap_load();
    check_frame(16'h2222, 1'b0, 4'hF, 5, 16'h1234, 23, 16'h5678);
    check_frame(16'h1234, 1'b1, 4'hF, -1, '0, -1, '0);
    check_frame(16'h5678, 1'b1, 4'hF, -1, '0, -1, '0);
    check_frame(16'h5678, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_mask();
    check_frame(16'h5678, 1'b0, 4'b0101, -1, '0, -1, '0);
    check_frame(16'h5678, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  task automatic test_async_reset();
    digit_en = 4'hF;
    load = 1'b1; value_in = 16'h9999;
    step();
    load = 1'b0;
    repeat (14) step();
    checks++;
    if (anode !== 4'hB) begin
      errors++; $display("FAIL pre_reset_anode got=%h want=B", anode);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (anode !== 4'hF) begin
      errors++; $display("FAIL async_anode got=%h want=F", anode);
    end
    checks++;
    if (nibble_out !== 4'h0 || frame_done !== 1'b0 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_outs got nib=%h fd=%b ack=%b want 0/0/0", nibble_out, frame_done, load_ack);
    end
    #1;
    rst_n = 1'b1;
    k = 0;
    check_frame(16'h0000, 1'b0, 4'hF, -1, '0, -1, '0);
    check_frame(16'h0000, 1'b0, 4'hF, -1, '0, -1, '0);
  endtask

  initial begin
    #12;
    test_reset();
    test_commit();
    test_overwrite();
    test_wrap_load();
    test_mask();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
